systolic_job_sequencer: RTL

- Sequences one matrix-multiply job at a time through the systolic array top level.
- Per job: resets both queue write pointers, streams N*N north (weight) words and then N*N west (data) words from a single operand stream into the queue write ports, and pulses start.
- Then waits for multiply completion and captures drain words into a result FIFO that feeds a backpressured result stream.
- Sits between the host/DMA side and the array top level.

---
 rtl/systolic_seq_pkg.sv | 28 ++
 rtl/seq_result_fifo.sv | 45 ++++
 rtl/systolic_job_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/systolic_seq_pkg.sv
// Shared state encoding, default geometry and result-entry layout for the systolic job sequencer.
package systolic_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_PTR_RST = 3'd1;
    localparam state_t S_LOAD_N  = 3'd2;
    localparam state_t S_LOAD_W  = 3'd3;
    localparam state_t S_START   = 3'd4;
    localparam state_t S_COMPUTE = 3'd5;
    localparam state_t S_DRAIN   = 3'd6;
    localparam state_t S_DONE    = 3'd7;

    localparam int SEQ_N          = 8;
    localparam int SEQ_DATA_WIDTH = 32;
    localparam int SEQ_ID_WIDTH   = 4;

    localparam int WORDS_PER_QUEUE = SEQ_N * SEQ_N;
    localparam int CNT_WIDTH       = $clog2(WORDS_PER_QUEUE + 1);

    typedef struct packed {
        logic [SEQ_ID_WIDTH-1:0]   id;
        logic                      last;
        logic [SEQ_DATA_WIDTH-1:0] data;
    } result_entry_t;

endpackage

// File: rtl/seq_result_fifo.sv
// First-word-fall-through FIFO: a word pushed in cycle T is at the head in T+1.
// Push while full is accepted only when a pop happens in the same cycle.
module seq_result_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/systolic_job_sequencer.sv
// Runs one matmul job: pointer reset, N*N north then N*N west loads, start, drain capture into a FWFT FIFO.
// Job accept to PTR_RST is one cycle; results are backpressured by res_ready_i, drain words are never stalled.
module systolic_job_sequencer
    import systolic_seq_pkg::*;
#(
    parameter int N              = SEQ_N,
    parameter int DATA_WIDTH     = SEQ_DATA_WIDTH,
    parameter int ID_WIDTH       = SEQ_ID_WIDTH,
    parameter int RESULT_COUNT   = N * N,
    parameter int FIFO_DEPTH     = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  job_valid_i,
    output logic                  job_ready_o,
    input  logic [ID_WIDTH-1:0]   job_id_i,
    input  logic                  op_valid_i,
    output logic                  op_ready_o,
    input  logic [DATA_WIDTH-1:0] op_data_i,
    output logic                  north_write_enable_o,
    output logic [DATA_WIDTH-1:0] north_write_data_o,
    output logic                  north_write_reset_o,
    output logic                  west_write_enable_o,
    output logic [DATA_WIDTH-1:0] west_write_data_o,
    output logic                  west_write_reset_o,
    output logic                  start_matrix_mult_o,
    input  logic                  matrix_mult_complete_i,
    input  logic                  drain_valid_i,
    input  logic [DATA_WIDTH-1:0] drain_data_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [DATA_WIDTH-1:0] res_data_o,
    output logic                  res_last_o,
    output logic [ID_WIDTH-1:0]   res_id_o,
    output logic                  busy_o,
    output logic                  timeout_o,
    output logic                  overflow_o,
    output logic [15:0]           jobs_done_o
);
    localparam int WORDS = N * N;
    localparam int CW    = $clog2(WORDS + 1);
    localparam int DCW   = $clog2(RESULT_COUNT + 1);
    localparam int WW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int EW    = ID_WIDTH + 1 + DATA_WIDTH;

    state_t              state;
    logic [CW-1:0]       word_cnt;
    logic [DCW-1:0]      drain_cnt;
    logic [DCW-1:0]      drain_cnt_nxt;
    logic [WW-1:0]       wd_cnt;
    logic [ID_WIDTH-1:0] job_id;

    logic          op_hs;
    logic          in_window;
    logic          push_req;
    logic          wd_expire;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [EW-1:0] push_entry;
    logic [EW-1:0] head_entry;

    assign job_ready_o          = (state == S_IDLE);
    assign busy_o               = (state != S_IDLE);
    assign north_write_reset_o  = (state == S_PTR_RST);
    assign west_write_reset_o   = (state == S_PTR_RST);
    assign start_matrix_mult_o  = (state == S_START);
    assign op_ready_o           = (state == S_LOAD_N) || (state == S_LOAD_W);
    assign op_hs                = op_valid_i && op_ready_o;
    assign north_write_enable_o = op_valid_i && (state == S_LOAD_N);
    assign west_write_enable_o  = op_valid_i && (state == S_LOAD_W);
    assign north_write_data_o   = north_write_enable_o ? op_data_i : '0;
    assign west_write_data_o    = west_write_enable_o ? op_data_i : '0;

    // Drain words past RESULT_COUNT are ignored; dropped (overflowed) words still count.
    assign in_window     = (state == S_COMPUTE) || (state == S_DRAIN);
    assign push_req      = in_window && drain_valid_i && (drain_cnt != DCW'(RESULT_COUNT));
    assign drain_cnt_nxt = drain_cnt + DCW'(push_req);
    assign wd_expire     = in_window && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
    assign push_entry    = {job_id, (drain_cnt == DCW'(RESULT_COUNT - 1)), drain_data_i};

    assign res_valid_o = !fifo_empty;
    assign fifo_pop    = res_valid_o && res_ready_i;
    assign fifo_push   = push_req && (!fifo_full || fifo_pop);
    assign {res_id_o, res_last_o, res_data_o} = head_entry;

    seq_result_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            word_cnt    <= '0;
            drain_cnt   <= '0;
            wd_cnt      <= '0;
            job_id      <= '0;
            timeout_o   <= 1'b0;
            overflow_o  <= 1'b0;
            jobs_done_o <= '0;
        end else begin
            if (push_req) drain_cnt <= drain_cnt_nxt;
            if (push_req && fifo_full && !fifo_pop) overflow_o <= 1'b1;
            if (in_window) wd_cnt <= wd_cnt + WW'(1);

            case (state)
                S_IDLE: begin
                    if (job_valid_i) begin
                        job_id    <= job_id_i;
                        timeout_o <= 1'b0;
                        state     <= S_PTR_RST;
                    end
                end
                S_PTR_RST: begin
                    word_cnt <= '0;
                    state    <= S_LOAD_N;
                end
                S_LOAD_N, S_LOAD_W: begin
                    if (op_hs) begin
                        if (word_cnt == CW'(WORDS - 1)) begin
                            word_cnt <= '0;
                            state    <= (state == S_LOAD_N) ? S_LOAD_W : S_START;
                        end else begin
                            word_cnt <= word_cnt + CW'(1);
                        end
                    end
                end
                S_START: begin
                    wd_cnt    <= '0;
                    drain_cnt <= '0;
                    state     <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    if (wd_expire) begin
                        timeout_o <= 1'b1;
                        state     <= S_DONE;
                    end else if (matrix_mult_complete_i) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // A full result set wins over a watchdog expiry in the same cycle.
                    if (drain_cnt_nxt == DCW'(RESULT_COUNT)) begin
                        state <= S_DONE;
                    end else if (wd_expire) begin
                        timeout_o <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    jobs_done_o <= jobs_done_o + 16'd1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
